// File: rtl/line_sync_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : line_sync_scheduler
//  Purpose  : Aligns the Ethernet receive FIFO line stream (FWFT, 29-bit words
//             {x_count[1:0], y_tag[10:0], Y[7:0], C[7:0]}) to the 74.25 MHz
//             video timing. Stale lines are discarded, missing or early lines
//             are replaced with black, and matching lines stream one word per
//             pixel request.
//  Options  : SYNC_STATS_EN - when defined, o_drop_cnt / o_miss_cnt are
//             16-bit saturating statistics counters; otherwise tied to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module line_sync_scheduler #(
   parameter logic [11:0] HSTART     = 12'd219,
   parameter logic [11:0] VSTART     = 12'd24,
   parameter logic [11:0] VFIN       = 12'd745,
   parameter logic [10:0] LINE_WORDS = 11'd1200,
   parameter logic [15:0] FILL_WORD  = 16'h1080
) (
   input  logic        i_clk_74M,
   input  logic        i_rst,
   input  logic [11:0] i_vcnt,
   input  logic [11:0] i_hcnt,
   input  logic        i_pix_req,
   input  logic [28:0] i_fifo_dout,
   input  logic        i_fifo_empty,
   output logic        o_fifo_rd,
   output logic [28:0] o_data,
   output logic [2:0]  o_state,
   output logic [15:0] o_drop_cnt,
   output logic [15:0] o_miss_cnt
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ALIGN  = 3'd1,
      ST_DROP   = 3'd2,
      ST_READY  = 3'd3,
      ST_STREAM = 3'd4,
      ST_MISS   = 3'd5,
      ST_DONE   = 3'd6
   } state_t;

   state_t      state_q, state_d;
   logic [10:0] pix_cnt_q, pix_cnt_d;
   logic [10:0] target_q;
   logic        active_q;

   logic [10:0] w_age;
   logic        w_match, w_stale;
   logic        w_line_start, w_vactive, w_last_pix;
   logic        w_rd;
   logic [28:0] w_data;

   // Modular age of the head line relative to the scanned line: 0 is a match,
   // 1..1023 is behind (stale), 1024..2047 is ahead (early).
   assign w_age        = target_q - i_fifo_dout[26:16];
   assign w_match      = !i_fifo_empty && (w_age == 11'd0);
   assign w_stale      = !i_fifo_empty && (w_age != 11'd0) && !w_age[10];
   assign w_line_start = (i_hcnt == 12'd0);
   assign w_vactive    = (i_vcnt >= VSTART) && (i_vcnt < VFIN);
   assign w_last_pix   = (pix_cnt_q == (LINE_WORDS - 11'd1));

   // Latch the line being scanned at the start of every line.
   always_ff @(posedge i_clk_74M) begin
      if (i_rst) begin
         target_q <= 11'd0;
         active_q <= 1'b0;
      end else if (w_line_start) begin
         active_q <= w_vactive;
         if (w_vactive) begin
            target_q <= i_vcnt[10:0] - VSTART[10:0];
         end
      end
   end

   // State and pixel-count registers.
   always_ff @(posedge i_clk_74M) begin
      if (i_rst) begin
         state_q   <= ST_IDLE;
         pix_cnt_q <= 11'd0;
      end else begin
         state_q   <= state_d;
         pix_cnt_q <= pix_cnt_d;
      end
   end

   // Next-state, pop request and zero-latency pixel data selection.
   always_comb begin
      state_d   = state_q;
      pix_cnt_d = pix_cnt_q;
      w_rd      = 1'b0;
      w_data    = {2'b00, target_q, FILL_WORD};
      case (state_q)
         ST_IDLE: begin
         end
         ST_ALIGN: begin
            pix_cnt_d = 11'd0;
            // Only judge the head once the scanned line is an active one.
            if (active_q) begin
               if (w_stale)      state_d = ST_DROP;
               else if (w_match) state_d = ST_READY;
               else              state_d = ST_MISS;
            end
         end
         ST_DROP: begin
            if (w_stale) begin
               w_rd = 1'b1;
            end else if (w_match && (i_hcnt < HSTART)) begin
               state_d = ST_READY;
            end
            // Too late to realign: the line goes out black.
            if (i_pix_req) begin
               pix_cnt_d = pix_cnt_q + 11'd1;
               if (w_last_pix) state_d = ST_DONE;
            end
         end
         ST_READY, ST_STREAM: begin
            // The first request in READY is already served from the FIFO.
            if (i_pix_req) begin
               pix_cnt_d = pix_cnt_q + 11'd1;
               state_d   = w_last_pix ? ST_DONE : ST_STREAM;
               if (i_fifo_empty) begin
                  w_data = {i_fifo_dout[28:27], target_q, FILL_WORD};
               end else begin
                  w_data = i_fifo_dout;
                  w_rd   = 1'b1;
               end
            end
         end
         ST_MISS: begin
            if (i_pix_req) begin
               pix_cnt_d = pix_cnt_q + 11'd1;
               if (w_last_pix) state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (w_line_start) begin
               if (w_vactive)            state_d = ST_ALIGN;
               else if (i_vcnt >= VFIN)  state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // Frame-level recovery: the top of every frame re-synchronises.
      if (i_vcnt == 12'd0) begin
         state_d = ST_ALIGN;
      end
   end

   assign o_fifo_rd = w_rd && !i_rst;
   assign o_data    = w_data;
   assign o_state   = state_q;

`ifdef SYNC_STATS_EN
   logic [15:0] drop_cnt_q, miss_cnt_q;
   logic        w_serve, w_drop_inc, w_miss_inc;

   assign w_serve    = (state_q == ST_READY) || (state_q == ST_STREAM);
   assign w_drop_inc = (state_q == ST_DROP) && o_fifo_rd;
   // One miss per black line, one per underrun pixel while streaming.
   assign w_miss_inc = ((state_q == ST_ALIGN) && (state_d == ST_MISS)) ||
                       ((state_q == ST_DROP) && i_pix_req && (pix_cnt_q == 11'd0)) ||
                       (w_serve && i_pix_req && i_fifo_empty);

   // Saturating statistics counters.
   always_ff @(posedge i_clk_74M) begin
      if (i_rst) begin
         drop_cnt_q <= 16'd0;
         miss_cnt_q <= 16'd0;
      end else begin
         if (w_drop_inc && (drop_cnt_q != 16'hFFFF)) drop_cnt_q <= drop_cnt_q + 16'd1;
         if (w_miss_inc && (miss_cnt_q != 16'hFFFF)) miss_cnt_q <= miss_cnt_q + 16'd1;
      end
   end

   assign o_drop_cnt = drop_cnt_q;
   assign o_miss_cnt = miss_cnt_q;
`else
   assign o_drop_cnt = 16'h0000;
   assign o_miss_cnt = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_line_sync_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_line_sync_scheduler
//  Purpose  : Self-checking bench for line_sync_scheduler. A line-level model
//             predicts every requested pixel into a scoreboard; a monitor
//             compares on each pixel request. Pops and counters are checked
//             at the end of each line.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_line_sync_scheduler;

   localparam logic [11:0] HSTART    = 12'd219;
   localparam logic [11:0] VSTART    = 12'd24;
   localparam logic [11:0] VFIN      = 12'd745;
   localparam int          LW        = 1200;
   localparam int          LINE_LEN  = 1440;
   localparam int          FAST_DROP = 200;   // drops clearly done before HSTART
   localparam logic [15:0] FILL      = 16'h1080;
   localparam logic [1:0]  EMPTY_X   = 2'b11;
   localparam logic [28:0] EMPTY_WORD = {EMPTY_X, 11'h7FF, 16'hDEAD};
   localparam logic [28:0] M_ALL     = 29'h1FFFFFFF;
   localparam logic [28:0] M_PIX     = 29'h0000FFFF;

   logic        clk = 1'b0;
   logic        rst, pix_req, fifo_empty, fifo_rd;
   logic [11:0] vcnt, hcnt;
   logic [28:0] fifo_dout, data;
   logic [2:0]  state;
   logic [15:0] drop_cnt, miss_cnt;

   always #5 clk = ~clk;

   line_sync_scheduler dut (
      .i_clk_74M   (clk),
      .i_rst       (rst),
      .i_vcnt      (vcnt),
      .i_hcnt      (hcnt),
      .i_pix_req   (pix_req),
      .i_fifo_dout (fifo_dout),
      .i_fifo_empty(fifo_empty),
      .o_fifo_rd   (fifo_rd),
      .o_data      (data),
      .o_state     (state),
      .o_drop_cnt  (drop_cnt),
      .o_miss_cnt  (miss_cnt)
   );

   typedef struct {
      logic [28:0] d;
      logic [28:0] m;
      bit          rd_chk;
      bit          rd;
   } exp_t;

   exp_t        sb[$];
   logic [28:0] fifo[$];   // FIFO seen by the DUT
   logic [28:0] mq[$];     // model's view of the FIFO
   int          total = 0, bad = 0;
   int          mdrop = 0, mmiss = 0;
   bit          m_idle = 1'b1;
   exp_t        mon_e;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic bit is_stale(input logic [10:0] t, input logic [10:0] tag);
      logic [10:0] a;
      a = t - tag;
      return (a >= 11'd1) && (a <= 11'd1023);
   endfunction

   task automatic push_exp(input logic [28:0] d, input logic [28:0] m, input bit rc, input bit rd);
      exp_t e;
      e.d = d; e.m = m; e.rd_chk = rc; e.rd = rd;
      sb.push_back(e);
   endtask

   task automatic push_line(input logic [10:0] tag, input int n);
      logic [28:0] w;
      for (int i = 0; i < n; i++) begin
         w = {2'($urandom), tag, 16'($urandom)};
         fifo.push_back(w);
         mq.push_back(w);
      end
   endtask

   // Line-level reference: decide the fate of a whole line from its head.
   task automatic model_line(input logic [10:0] t, input int rst_at, output int pops);
      int          k;
      logic [28:0] hw;
      pops = 0;
      k    = 0;
      if (m_idle) begin
         for (int i = 0; i < LW; i++) push_exp({13'd0, FILL}, M_PIX, 1'b1, 1'b0);
         return;
      end
      while (mq.size() > 0) begin
         hw = mq[0];
         if (!is_stale(t, hw[26:16])) break;
         void'(mq.pop_front());
         k++;
      end
      mdrop += k;
      pops   = k;
      hw     = (mq.size() > 0) ? mq[0] : EMPTY_WORD;
      if (mq.size() > 0 && hw[26:16] == t && k <= FAST_DROP) begin
         for (int i = 0; i < LW; i++) begin
            if (i == rst_at) begin
               push_exp(29'd0, 29'd0, 1'b1, 1'b0);
               mq.delete();
               mdrop  = 0;
               mmiss  = 0;
               m_idle = 1'b1;
            end else if (rst_at >= 0 && i > rst_at) begin
               push_exp({13'd0, FILL}, M_PIX, 1'b1, 1'b0);
            end else if (mq.size() > 0) begin
               hw = mq.pop_front();
               push_exp(hw, M_ALL, 1'b1, 1'b1);
               pops++;
            end else begin
               push_exp({EMPTY_X, t, FILL}, M_ALL, 1'b1, 1'b0);
               mmiss++;
            end
         end
      end else begin
         mmiss++;
         for (int i = 0; i < LW; i++) push_exp({13'd0, FILL}, M_PIX, (k <= FAST_DROP), 1'b0);
      end
   endtask

   task automatic drive_fifo();
      fifo_empty = (fifo.size() == 0);
      fifo_dout  = fifo_empty ? EMPTY_WORD : fifo[0];
   endtask

   task automatic run_line(input logic [11:0] v, input int rst_at, input int exp_pops);
      bit act, chk_rst, rd_s;
      int len, pix, pops;
      act     = (v >= VSTART) && (v < VFIN);
      len     = act ? LINE_LEN : 16;
      pix     = 0;
      pops    = 0;
      chk_rst = 1'b0;
      for (int h = 0; h < len; h++) begin
         vcnt    = v;
         hcnt    = 12'(h);
         pix_req = act && (h >= int'(HSTART)) && (h < int'(HSTART) + LW);
         rst     = pix_req && (pix == rst_at);
         drive_fifo();
         @(negedge clk);
         if (chk_rst) begin
            check("rst_state", 32'(state), 32'd0);
            check("rst_rd", 32'(fifo_rd), 32'd0);
            check("rst_data", 32'(data), {19'd0, 13'd0} | 32'(FILL));
            check("rst_drop", 32'(drop_cnt), 32'd0);
            check("rst_miss", 32'(miss_cnt), 32'd0);
            chk_rst = 1'b0;
         end
         rd_s = fifo_rd;
         @(posedge clk);
         #1;
         if (rd_s && fifo.size() > 0) begin
            void'(fifo.pop_front());
            pops++;
         end
         if (rst) begin
            fifo.delete();
            chk_rst = 1'b1;
         end
         if (pix_req) pix++;
         rst = 1'b0;
      end
      pix_req = 1'b0;
      drive_fifo();
      check("line_pops", 32'(pops), 32'(exp_pops));
`ifdef SYNC_STATS_EN
      check("drop_cnt", 32'(drop_cnt), 32'(16'(mdrop)));
      check("miss_cnt", 32'(miss_cnt), 32'(16'(mmiss)));
`else
      check("drop_cnt", 32'(drop_cnt), 32'd0);
      check("miss_cnt", 32'(miss_cnt), 32'd0);
`endif
   endtask

   task automatic do_line(input logic [11:0] v, input int rst_at);
      int ep;
      ep = 0;
      if (v == 12'd0) m_idle = 1'b0;
      if (v >= VSTART && v < VFIN) model_line(11'(v - VSTART), rst_at, ep);
      run_line(v, rst_at, ep);
   endtask

   // Monitor: every pixel request is judged against the next prediction.
   always @(negedge clk) begin
      if (pix_req === 1'b1) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_empty: pixel request with no prediction (t=%0t)", $time);
         end else begin
            mon_e = sb.pop_front();
            if (mon_e.m != 29'd0) check("pix_data", 32'(data & mon_e.m), 32'(mon_e.d & mon_e.m));
            if (mon_e.rd_chk)     check("pix_rd", 32'(fifo_rd), 32'(mon_e.rd));
         end
      end
   end

   initial begin
      rst     = 1'b1;
      pix_req = 1'b0;
      vcnt    = 12'd700;
      hcnt    = 12'd5;
      drive_fifo();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_state", 32'(state), 32'd0);
      check("reset_rd", 32'(fifo_rd), 32'd0);
      check("reset_data", 32'(data), 32'(FILL));
      check("reset_drop", 32'(drop_cnt), 32'd0);
      check("reset_miss", 32'(miss_cnt), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Frame 1: in-order lines, empty, underrun, stale drop, early, long drop.
      do_line(12'd0, -1);
      for (int t = 0; t < 4; t++) begin
         push_line(11'(t), LW);
         do_line(VSTART + 12'(t), -1);
      end
      do_line(12'd28, -1);                                   // empty -> black
      push_line(11'd5, 600);  do_line(12'd29, -1);           // underrun at 600
      push_line(11'd6, LW);   do_line(12'd30, -1);           // realigns
      push_line(11'd5, 100); push_line(11'd6, 50); push_line(11'd7, LW);
      do_line(12'd31, -1);                                   // short drop, stream
      push_line(11'd8, LW);   do_line(12'd32, -1);
      push_line(11'd10, LW);  do_line(12'd33, -1);           // early -> black
      do_line(12'd34, -1);                                   // tag 10 streams
      push_line(11'd3, 1000); do_line(12'd35, -1);           // long drop -> black
      push_line(11'd12, LW);  do_line(12'd36, -1);
      do_line(VFIN, -1);

      // Frame 2: tag wrap stale, late drop, reset mid-stream at pixel 300.
      do_line(12'd0, -1);
      push_line(11'd2047, 500); push_line(11'd0, LW);
      do_line(12'd24, -1);
      do_line(12'd25, -1);
      push_line(11'd2, LW);
      do_line(12'd26, 300);
      do_line(12'd27, -1);
      do_line(VFIN, -1);

      // Frame 3: recovery after reset.
      do_line(12'd0, -1);
      push_line(11'd0, LW);   do_line(12'd24, -1);
      push_line(11'd1, LW);   do_line(12'd25, -1);
      do_line(VFIN, -1);

      check("sb_leftover", 32'(sb.size()), 32'd0);
      check("fifo_leftover", 32'(fifo.size()), 32'(mq.size()));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
